// File: rtl/sha1_pkg.sv
// Shared constants and types for the SHA-1 Wishbone controller.
// IV, round constants, register word offsets and FSM state encoding.
package sha1_pkg;

    localparam logic [31:0] SHA1_IV [5] = '{
        32'h6745_2301, 32'hEFCD_AB89, 32'h98BA_DCFE,
        32'h1032_5476, 32'hC3D2_E1F0
    };

    localparam logic [31:0] SHA1_K [4] = '{
        32'h5A82_7999, 32'h6ED9_EBA1,
        32'h8F1B_BCDC, 32'hCA62_C1D6
    };

    localparam logic [5:0] OFF_CTRL   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_MSG_LO = 6'd4;
    localparam logic [5:0] OFF_MSG_HI = 6'd19;
    localparam logic [5:0] OFF_DIG_LO = 6'd20;
    localparam logic [5:0] OFF_DIG_HI = 6'd24;

    localparam logic [6:0] LAST_RND = 7'd79;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_UPDATE
    } state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_vars_t;

    function automatic logic [31:0] rotl(
        input logic [31:0] x,
        input int unsigned n
    );
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sha1_wb_ctrl_if.sv
// Wishbone slave bus bundle for the SHA-1 controller.
// Master drives the request, slave returns ack and read data.
interface sha1_wb_ctrl_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/sha1_round.sv
// One SHA-1 round: working variables, schedule word, round index
// in; next working variables out. Purely combinational.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_vars_t  v_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  rnd_i,
    output sha1_vars_t  v_o
);

    logic [31:0] f;
    logic [31:0] k;

    // Pick the boolean function and constant for this 20-round group
    always_comb begin
        f = v_i.b ^ v_i.c ^ v_i.d;
        k = SHA1_K[3];
        unique case (1'b1)
            (rnd_i < 7'd20): begin
                f = (v_i.b & v_i.c) | (~v_i.b & v_i.d);
                k = SHA1_K[0];
            end
            (rnd_i >= 7'd20 && rnd_i < 7'd40): begin
                f = v_i.b ^ v_i.c ^ v_i.d;
                k = SHA1_K[1];
            end
            (rnd_i >= 7'd40 && rnd_i < 7'd60): begin
                f = (v_i.b & v_i.c) | (v_i.b & v_i.d)
                  | (v_i.c & v_i.d);
                k = SHA1_K[2];
            end
            (rnd_i >= 7'd60): begin
                f = v_i.b ^ v_i.c ^ v_i.d;
                k = SHA1_K[3];
            end
        endcase
    end

    // Rotate the working variables through one round
    always_comb begin
        v_o.a = rotl(v_i.a, 5) + f + v_i.e + k + w_i;
        v_o.b = v_i.a;
        v_o.c = rotl(v_i.b, 30);
        v_o.d = v_i.c;
        v_o.e = v_i.d;
    end

endmodule

// File: rtl/sha1_wb_ctrl.sv
// Wishbone register file and round sequencer for single-block
// SHA-1: message buffer, chained digest, control/status, irq.
module sha1_wb_ctrl
    import sha1_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               active,
    sha1_wb_ctrl_if.slave      wb,
    output logic               irq
);

    state_e      state_q, state_d;
    logic [6:0]  rnd_q, rnd_d;
    sha1_vars_t  v_q, v_d, v_nxt;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] h_q [5];
    logic [31:0] h_d [5];
    logic [31:0] msg_q [16];
    logic [31:0] msg_d [16];
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        hit;
    logic        busy;
    logic [5:0]  off;
    logic [5:0]  moff;
    logic [5:0]  hoff;
    logic        msg_hit;
    logic        dig_hit;
    logic [31:0] rdata;
    logic [31:0] w_new;
    logic        start_w;
    logic        init_w;
    logic        clr_done;
    logic [1:0]  unused_adr;

    assign unused_adr = wb.wbs_adr_i[1:0];
    assign off     = wb.wbs_adr_i[7:2];
    assign moff    = off - OFF_MSG_LO;
    assign hoff    = off - OFF_DIG_LO;
    assign msg_hit = (off >= OFF_MSG_LO) && (off <= OFF_MSG_HI);
    assign dig_hit = (off >= OFF_DIG_LO) && (off <= OFF_DIG_HI);
    assign busy    = (state_q != ST_IDLE);
    assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & active
                   & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_new   = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq          = done_q & irq_en_q;

    sha1_round u_round (
        .v_i   (v_q),
        .w_i   (w_q[0]),
        .rnd_i (rnd_q),
        .v_o   (v_nxt)
    );

    // Read multiplexer; unmapped offsets return zero
    always_comb begin
        rdata = '0;
        if (off == OFF_CTRL)
            rdata = {29'd0, irq_en_q, 2'b00};
        else if (off == OFF_STATUS)
            rdata = {30'd0, done_q, busy};
        else if (msg_hit)
            rdata = msg_q[moff[3:0]];
        else if (dig_hit)
            rdata = h_q[hoff[2:0]];
    end

    // Bus decode, register writes and round sequencing
    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        v_d      = v_q;
        w_d      = w_q;
        h_d      = h_q;
        msg_d    = msg_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        start_w  = 1'b0;
        init_w   = 1'b0;
        clr_done = 1'b0;
        ack_d    = hit & ~ack_q;
        dat_d    = ack_d ? rdata : 32'd0;

        if (ack_d && wb.wbs_we_i) begin
            if (off == OFF_CTRL) begin
                if (wb.wbs_sel_i[0]) begin
                    irq_en_d = wb.wbs_dat_i[2];
                    init_w   = wb.wbs_dat_i[1] & ~busy;
                    start_w  = wb.wbs_dat_i[0] & ~busy;
                end
            end else if (off == OFF_STATUS) begin
                clr_done = wb.wbs_dat_i[1];
            end else if (msg_hit) begin
                for (int l = 0; l < 4; l++) begin
                    if (wb.wbs_sel_i[l])
                        msg_d[moff[3:0]][8*l +: 8] =
                            wb.wbs_dat_i[8*l +: 8];
                end
            end
        end

        if (init_w) begin
            for (int i = 0; i < 5; i++)
                h_d[i] = SHA1_IV[i];
        end

        if (clr_done)
            done_d = 1'b0;

        if (!active) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_w) begin
                        state_d = ST_ROUND;
                        rnd_d   = 7'd0;
                        w_d     = msg_q;
                        v_d     = sha1_vars_t'{
                            a: h_d[0], b: h_d[1], c: h_d[2],
                            d: h_d[3], e: h_d[4]
                        };
                        done_d  = 1'b0;
                    end
                end
                ST_ROUND: begin
                    v_d = v_nxt;
                    for (int i = 0; i < 15; i++)
                        w_d[i] = w_q[i+1];
                    w_d[15] = w_new;
                    if (rnd_q == LAST_RND) begin
                        state_d = ST_UPDATE;
                        rnd_d   = 7'd0;
                    end else begin
                        rnd_d = rnd_q + 7'd1;
                    end
                end
                ST_UPDATE: begin
                    h_d[0]  = h_q[0] + v_q.a;
                    h_d[1]  = h_q[1] + v_q.b;
                    h_d[2]  = h_q[2] + v_q.c;
                    h_d[3]  = h_q[3] + v_q.d;
                    h_d[4]  = h_q[4] + v_q.e;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and register file flops
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= ST_IDLE;
            rnd_q    <= '0;
            v_q      <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i]   <= '0;
                msg_q[i] <= '0;
            end
            for (int i = 0; i < 5; i++)
                h_q[i] <= SHA1_IV[i];
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            v_q      <= v_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            w_q      <= w_d;
            msg_q    <= msg_d;
            h_q      <= h_d;
        end
    end

endmodule
